vector_ex_mem_pipe: RTL and testbench

VECTOR_EX_MEM_PIPE -- requirements
Module: vector_ex_mem_pipe

---
 rtl/vector_ex_mem_pipe.sv | 141 ++++++++++++++
 tb/tb_vector_ex_mem_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_ex_mem_pipe.sv
// Two-entry skid buffer between the vector execute stage and the memory stage.
// Optional VEC_PIPE_STALL_COUNT_EN adds a saturating 16-bit output-stall counter.
module vector_ex_mem_pipe #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LANES         = 8,
  parameter int unsigned SELECTOR_SIZE = 4,
  parameter int unsigned RD_WIDTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_result,
  input  logic [SELECTOR_SIZE-1:0]    in_selector,
  input  logic [RD_WIDTH-1:0]         in_rd,
  input  logic                        in_wr_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_result,
  output logic [SELECTOR_SIZE-1:0]    out_selector,
  output logic [RD_WIDTH-1:0]         out_rd,
  output logic                        out_wr_en
`ifdef VEC_PIPE_STALL_COUNT_EN
  ,
  output logic [15:0]                 stall_count
`endif
);

  localparam int unsigned RES_W = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [RES_W-1:0]         result;
    logic [SELECTOR_SIZE-1:0] sel;
    logic [RD_WIDTH-1:0]      rd;
    logic                     wr_en;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry_c;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   in_fire_c, out_fire_c;

  assign in_entry_c = '{result: in_result, sel: in_selector, rd: in_rd, wr_en: in_wr_en};
  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;

  // Next-state: flush wins over any transfer; ready/valid are re-registered from the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          main_d  = in_entry_c;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = in_entry_c;
        end else if (in_fire_c) begin
          skid_d  = in_entry_c;
          state_d = FULL;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire_c) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = main_q.result;
  assign out_selector = main_q.sel;
  assign out_rd       = main_q.rd;
  assign out_wr_en    = main_q.wr_en;

`ifdef VEC_PIPE_STALL_COUNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of back-pressured cycles; survives flush, cleared only by reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vector_ex_mem_pipe.sv
// Self-checking bench for vector_ex_mem_pipe: vector table plus scoreboard queue.
// Define VEC_PIPE_STALL_COUNT_EN to also exercise the stall counter.
module tb_vector_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [3:0]  in_selector;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_selector;
  logic [3:0]  out_rd;
  logic        out_wr_en;
`ifdef VEC_PIPE_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       v;
    logic       r;
    logic       f;
    logic [7:0] b;
    logic       eir;
    logic       eov;
  } vec_t;

  vec_t tbl[$];

  vector_ex_mem_pipe #(
    .DATA_WIDTH(8), .LANES(8), .SELECTOR_SIZE(4), .RD_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_selector(in_selector), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_selector(out_selector), .out_rd(out_rd), .out_wr_en(out_wr_en)
`ifdef VEC_PIPE_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    in_result   = {8{b}};
    in_selector = b[3:0];
    in_rd       = ~b[3:0];
    in_wr_en    = b[0];
  endtask

  task automatic chk_entry(input logic [7:0] b);
    logic [3:0] nb;
    nb = ~b[3:0];
    chk("out_result", out_result, {8{b}});
    chk("out_selector", 64'(out_selector), 64'(b[3:0]));
    chk("out_rd", 64'(out_rd), 64'(nb));
    chk("out_wr_en", 64'(out_wr_en), 64'(b[0]));
  endtask

  // Called at a negedge; checks current outputs, updates the model, advances one cycle.
  task automatic step(input logic v, input logic r, input logic f, input logic [7:0] b,
                      input logic eir, input logic eov);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    drive(b);
    #1;
    chk("in_ready", 64'(in_ready), 64'(eir));
    chk("out_valid", 64'(out_valid), 64'(eov));
    if (eov) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 64'(0), 64'(1));
      end else begin
        chk_entry(sb[0]);
      end
    end
    if (f) begin
      sb.delete();
    end else begin
      if (eov && r) void'(sb.pop_front());
      if (v && eir) sb.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic v, logic r, logic f, logic [7:0] b, logic eir, logic eov);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.b = b; t.eir = eir; t.eov = eov;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(8'h00);

    // Idle, single transfer, backpressure ordering, flush while FULL, FULL drain
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h11, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h01, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h02, 1, 1));
    tbl.push_back(mk(1, 0, 0, 8'h03, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h03, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h03, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h0A, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h0B, 1, 1));
    tbl.push_back(mk(1, 0, 1, 8'h0C, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h21, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h22, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0));

    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", out_result, 64'(0));
    chk("rst_out_fields", 64'({out_selector, out_rd, out_wr_en}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].eir, tbl[i].eov);
    end
    chk("sb_empty_after_table", 64'(sb.size()), 64'(0));

    // Back-to-back stream of 16 results
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), 1'b1, (i != 0));
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("sb_empty_after_stream", 64'(sb.size()), 64'(0));

    // Asynchronous reset while FULL, away from any clock edge
    step(1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h78, 1'b1, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_in_ready", 64'(in_ready), 64'(1));
    chk("async_out_result", out_result, 64'(0));
    chk("async_out_fields", 64'({out_selector, out_rd, out_wr_en}), 64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef VEC_PIPE_STALL_COUNT_EN
    chk("stall_start", 64'(stall_count), 64'(0));
    step(1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_5", 64'(stall_count), 64'(5));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("stall_kept_on_flush", 64'(stall_count), 64'(6));
    step(1'b1, 1'b0, 1'b0, 8'h9A, 1'b1, 1'b0);
    repeat (65534 - 6) @(negedge clk);
    chk("stall_fffe", 64'(stall_count), 64'(16'hFFFE));
    repeat (3) @(negedge clk);
    chk("stall_sat", 64'(stall_count), 64'(16'hFFFF));
    out_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
